// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq
// Brief    : 8x8 unsigned multiply / 8/8 unsigned divide sequenced onto the
//            shared datapath ALU, one ALU operation per cycle.
// Revision : 1.0  initial release
// ============================================================================
module alu_muldiv_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] res_hi,
    output logic [7:0] res_lo,
    output logic       div0,
    output logic [7:0] alu_opA,
    output logic [7:0] alu_opB,
    output logic [2:0] alu_op,
    output logic [1:0] alu_funct,
    input  logic [7:0] alu_result,
    input  logic       alu_zero
);

    localparam logic [2:0] C_ALU_AND = 3'd0;
    localparam logic [2:0] C_ALU_ADD = 3'd2;
    localparam logic [2:0] C_ALU_SUB = 3'd3;
    localparam logic [2:0] C_ALU_SLT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_STEP = 3'd1,
        S_DIV_CMP  = 3'd2,
        S_DIV_SUB  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t     state_q;
    logic [2:0] step_q;
    // hi_q: accumulator (MUL) / partial remainder (DIV)
    // lo_q: multiplier shift register (MUL) / quotient shift register (DIV)
    // opnd_q: multiplicand (MUL) / divisor (DIV)
    logic [7:0] hi_q, lo_q, opnd_q;
    logic       ge_q;
    logic       busy_q, done_q, div0_q;
    logic [7:0] res_hi_q, res_lo_q;

    logic       carry_d;
    logic [7:0] mul_hi_d, mul_lo_d, shift_d, rem_d;

    always_comb begin
        carry_d  = (alu_result < hi_q);
        mul_hi_d = {carry_d, alu_result[7:1]};
        mul_lo_d = {alu_result[0], lo_q[7:1]};
        shift_d  = {hi_q[6:0], lo_q[7]};
        rem_d    = ge_q ? alu_result : hi_q;
    end

    always_comb begin
        alu_opA = 8'd0;
        alu_opB = 8'd0;
        alu_op  = C_ALU_AND;
        case (state_q)
            S_MUL_STEP: begin
                alu_opA = hi_q;
                alu_opB = lo_q[0] ? opnd_q : 8'd0;
                alu_op  = C_ALU_ADD;
            end
            S_DIV_CMP: begin
                alu_opA = shift_d;
                alu_opB = opnd_q;
                alu_op  = C_ALU_SLT;
            end
            S_DIV_SUB: begin
                alu_opA = hi_q;
                alu_opB = opnd_q;
                alu_op  = C_ALU_SUB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            step_q   <= 3'd0;
            hi_q     <= 8'd0;
            lo_q     <= 8'd0;
            opnd_q   <= 8'd0;
            ge_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
            res_hi_q <= 8'd0;
            res_lo_q <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        div0_q <= 1'b0;
                        step_q <= 3'd0;
                        busy_q <= 1'b1;
                        hi_q   <= 8'd0;
                        lo_q   <= a;
                        opnd_q <= b;
                        if (!op) begin
                            state_q <= S_MUL_STEP;
                        end else if (b != 8'd0) begin
                            state_q <= S_DIV_CMP;
                        end else begin
                            res_hi_q <= a;
                            res_lo_q <= 8'hFF;
                            div0_q   <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_MUL_STEP: begin
                    hi_q   <= mul_hi_d;
                    lo_q   <= mul_lo_d;
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd7) begin
                        res_hi_q <= mul_hi_d;
                        res_lo_q <= mul_lo_d;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DIV_CMP: begin
                    // alu_zero from SLT means shifted remainder >= divisor
                    hi_q    <= shift_d;
                    lo_q    <= {lo_q[6:0], alu_zero};
                    ge_q    <= alu_zero;
                    state_q <= S_DIV_SUB;
                end
                S_DIV_SUB: begin
                    hi_q   <= rem_d;
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd7) begin
                        res_hi_q <= rem_d;
                        res_lo_q <= lo_q;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        state_q <= S_DIV_CMP;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign div0      = div0_q;
    assign res_hi    = res_hi_q;
    assign res_lo    = res_lo_q;
    assign alu_funct = 2'b00;

endmodule
`default_nettype wire
